// File: rtl/midi_uart_rx_pkg.sv
// Shared MIDI definitions: line rate, default clock and the receiver state
// encoding (also exported to the parser's debug port).
package midi_uart_rx_pkg;

  localparam int MIDI_BAUD       = 31250;
  localparam int DEF_CLK_FREQ_HZ = 25000000;
  localparam int CNT_W           = 13;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } midi_rx_state_e;

endpackage

// File: rtl/midi_uart_rx_sync_ff.sv
// Multi-flop synchroniser for asynchronous single-bit inputs; resets to 1 so
// an idle-high line does not look like an edge when reset is released.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '1;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver: mid-bit sampling from a start-edge-aligned
// counter, one-cycle byte/framing strobes, break recovery via WAIT_IDLE.
module midi_uart_rx
  import midi_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = MIDI_BAUD,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int CPB  = CLK_FREQ_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic rx_s, rx_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (midi_rx),
    .q_o   (rx_s)
  );

  midi_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_q    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first, ends in bit 0
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Require a sustained high so a held-low (break) line yields one error.
        if (!rx_s) cnt_d = '0;
        else if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign byte_valid    = valid_q;
  assign byte_data     = data_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at a reduced clock (CPB=80) so that all
// scenarios, including the 5 ms break, stay short.
module tb_midi_uart_rx;

  localparam int CLK_HZ = 2500000;
  localparam int CPB    = CLK_HZ / 31250;   // 80
  localparam int HALF   = CPB / 2;          // 40
  localparam int SYNC   = 2;
  localparam int CLK_HP = 200;
  localparam realtime BIT_NOM = 2.0 * CLK_HP * CPB;

  logic       clk, rst_n, midi_rx;
  logic       byte_valid, framing_error, rx_busy;
  logic [7:0] byte_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nferr = 0;
  int nboth = 0;
  int fall_cyc;
  logic [7:0] q_data[$];
  int         q_cyc[$];

  midi_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(31250), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .midi_rx       (midi_rx),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #CLK_HP clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      q_data.push_back(byte_data);
      q_cyc.push_back(cyc);
    end
    if (framing_error) nferr <= nferr + 1;
    if (byte_valid && framing_error) nboth <= nboth + 1;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input realtime bit_t);
    @(negedge clk);
    fall_cyc = cyc;
    midi_rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      #(bit_t);
    end
    midi_rx = stop;
    #(bit_t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", byte_valid); end
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", byte_data); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", framing_error); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int base = q_data.size();
    int fe0 = nferr;
    int lat;
    send_frame(8'h90, 1'b1, BIT_NOM);
    repeat (2 * CPB) @(negedge clk);
    total++; if (q_data.size() - base !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", q_data.size() - base); end
    if (q_data.size() > base) begin
      lat = q_cyc[base] - fall_cyc;
      total++; if (q_data[base] !== 8'h90) begin bad++; $display("FAIL single_data got=%h exp=90", q_data[base]); end
      total++;
      if (lat < SYNC + HALF + 9 * CPB + 1 || lat > SYNC + HALF + 9 * CPB + 3) begin
        bad++; $display("FAIL single_latency got=%0d exp=%0d+-1", lat, SYNC + HALF + 9 * CPB + 2);
      end
    end
    total++; if (byte_data !== 8'h90) begin bad++; $display("FAIL single_hold got=%h exp=90", byte_data); end
    total++; if (nferr !== fe0) begin bad++; $display("FAIL single_ferr got=%0d exp=%0d", nferr, fe0); end
  endtask

  task automatic test_glitch();
    int base = q_data.size();
    int fe0 = nferr;
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", rx_busy); end
    repeat (5) @(negedge clk);
    midi_rx = 1'b1;
    repeat (HALF + SYNC + 2 - 10) @(negedge clk);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", rx_busy); end
    repeat (CPB) @(negedge clk);
    total++; if (q_data.size() !== base) begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", q_data.size(), base); end
    total++; if (nferr !== fe0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=%0d", nferr, fe0); end
  endtask

  task automatic test_back_to_back();
    int base = q_data.size();
    int fe0 = nferr;
    logic [7:0] exp [3] = '{8'h90, 8'h3C, 8'h64};
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, BIT_NOM);
    repeat (2 * CPB) @(negedge clk);
    total++; if (q_data.size() - base !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", q_data.size() - base); end
    if (q_data.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (q_data[base+i] !== exp[i]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, q_data[base+i], exp[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (q_cyc[base+i] - q_cyc[base+i-1] !== 10 * CPB) begin
          bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, q_cyc[base+i] - q_cyc[base+i-1], 10 * CPB);
        end
      end
    end
    total++; if (nferr !== fe0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=%0d", nferr, fe0); end
  endtask

  task automatic test_framing();
    int base = q_data.size();
    int fe0 = nferr;
    send_frame(8'h55, 1'b0, BIT_NOM);
    repeat (12500) @(negedge clk);   // 5 ms of continuous low
    midi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (nferr - fe0 !== 1) begin bad++; $display("FAIL frame_ferr_count got=%0d exp=1", nferr - fe0); end
    total++; if (q_data.size() !== base) begin bad++; $display("FAIL frame_no_valid got=%0d exp=%0d", q_data.size(), base); end
    total++; if (byte_data !== 8'h64) begin bad++; $display("FAIL frame_data_held got=%h exp=64", byte_data); end
    send_frame(8'hB0, 1'b1, BIT_NOM);
    repeat (2 * CPB) @(negedge clk);
    total++; if (q_data.size() - base !== 1) begin bad++; $display("FAIL frame_recover_count got=%0d exp=1", q_data.size() - base); end
    total++; if (byte_data !== 8'hB0) begin bad++; $display("FAIL frame_recover_data got=%h exp=b0", byte_data); end
  endtask

  task automatic test_reset_mid_frame();
    int base = q_data.size();
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    midi_rx = 1'b1;                    // 8'hFF: every data bit high
    repeat (4 * CPB + HALF) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", byte_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", byte_valid); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", framing_error); end
    rst_n = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    total++; if (q_data.size() !== base) begin bad++; $display("FAIL rstmid_aborted got=%0d exp=%0d", q_data.size(), base); end
    send_frame(8'h7F, 1'b1, BIT_NOM);
    repeat (2 * CPB) @(negedge clk);
    total++; if (q_data.size() - base !== 1) begin bad++; $display("FAIL rstmid_next_count got=%0d exp=1", q_data.size() - base); end
    total++; if (byte_data !== 8'h7F) begin bad++; $display("FAIL rstmid_next_data got=%h exp=7f", byte_data); end
  endtask

  task automatic test_tolerance(input realtime bit_t, input string tag);
    int base = q_data.size();
    logic [7:0] exp [3] = '{8'hA5, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, bit_t);
    midi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (q_data.size() - base !== 3) begin bad++; $display("FAIL tol_%s_count got=%0d exp=3", tag, q_data.size() - base); end
    if (q_data.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (q_data[base+i] !== exp[i]) begin bad++; $display("FAIL tol_%s_data%0d got=%h exp=%h", tag, i, q_data[base+i], exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_back_to_back();
    test_framing();
    test_reset_mid_frame();
    test_tolerance(BIT_NOM / 1.02, "fast");
    test_tolerance(BIT_NOM / 0.98, "slow");
    total++; if (nboth !== 0) begin bad++; $display("FAIL valid_and_ferr_together got=%0d exp=0", nboth); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
Serial front end of the MIDI path. It converts the raw opto-isolated MIDI input (31250 baud, 8N1, LSB first, idle high) into one-cycle byte strobes with 8-bit data. It feeds the MIDI message parser, which consumes byte_valid/byte_data directly. It also detects false starts and framing errors, and resynchronises after line faults.

Parameters:
CLK_FREQ_HZ, 25000000, system clock frequency in Hz.
BAUD, 31250, serial bit rate.
SYNC_STAGES, 2, number of input synchroniser flops; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
midi_rx  input  1  asynchronous serial MIDI line, idle high
byte_valid  output  1  one-cycle strobe; byte_data holds a good byte
byte_data  output  8  last good received byte; holds until the next byte_valid
framing_error  output  1  one-cycle strobe; stop bit sampled low
rx_busy  output  1  high while a frame is in progress (START/DATA/STOP)

Behaviour:
- Constants: CPB = CLK_FREQ_HZ/BAUD (integer division; 800 at defaults). HALF = CPB/2 (400). Bit counter 13 bits wide (covers CPB up to 8191).
- Reset (rst_n low, asynchronous): all synchroniser flops = 1 (idle), state = IDLE, counters = 0, byte_valid = 0, byte_data = 8'h00, framing_error = 0, rx_busy = 0.
- Synchroniser: midi_rx passes through SYNC_STAGES flops to give rx_s. rx_q is rx_s delayed by one cycle. Start edge = rx_q==1 && rx_s==0.
- IDLE: on start edge, go to START, cnt = 0. Call that cycle t0.
- START: cnt increments each cycle. At cnt == HALF-1 (cycle t0+HALF), sample rx_s.
  - If rx_s==1: false start. Return to IDLE; no strobe.
  - If rx_s==0: go to DATA, cnt = 0, bit index = 0.
- DATA: when cnt == CPB-1, sample rx_s into shift register bit[idx] (LSB first), then cnt = 0, idx += 1. After idx 7 is sampled, go to STOP. Data bit i is sampled at t0+HALF+(i+1)*CPB.
- STOP: stop bit sampled at t0+HALF+9*CPB.
  - rx_s==1: byte_data <= shift register and byte_valid = 1 on the next cycle; state returns to IDLE on that sample cycle. A start edge arriving immediately after mid-stop must be accepted (back-to-back frames, zero idle gap).
  - rx_s==0: framing_error = 1 on the next cycle; byte_data unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1 for HALF consecutive cycles, then go to IDLE. This covers MIDI cable unplug/break: a continuous low produces exactly one framing_error, not repeated frames.
- rx_busy = 1 in START, DATA, STOP; 0 in IDLE and WAIT_IDLE.
- byte_valid and framing_error are never high in the same cycle. Each is high for exactly one cycle per frame.
- Latency: byte_valid rises SYNC_STAGES + HALF + 9*CPB + 2 cycles after the midi_rx falling edge, ±1 cycle for synchroniser phase.
- Reset mid-frame: the partial frame is discarded with no strobe. After release, the first full frame is received normally.
- Tolerance: the block must decode correctly with a transmitter rate error of ±2%.

Decomposition:
- Shared midi package:
  - MIDI_BAUD = 31250.
  - Default CLK_FREQ_HZ.
  - State enum {IDLE, START, DATA, STOP, WAIT_IDLE} as a 3-bit typedef, shared with the parser's debug export.
- One natural sub-module: sync_ff (SYNC_STAGES-deep reset-to-1 synchroniser), reusable for other asynchronous inputs (buttons, gate inputs).
- FSM, counters and shift register stay in midi_uart_rx.

Test Plan:
- Single byte 8'h90, exact 31250 baud, then idle -> exactly one byte_valid, byte_data = 8'h90 at the latency given above, framing_error never high.
- Low glitch of 100 cycles (< HALF) on idle line -> no byte_valid, no framing_error, rx_busy back to 0 within HALF+SYNC_STAGES+2 cycles.
- Back-to-back 8'h90, 8'h3C, 8'h64 with zero idle gap -> three byte_valid pulses 10*CPB apart, data in order 8'h90, 8'h3C, 8'h64.
- Frame 8'h55 with stop bit forced low, then line low for 5 ms, then 8'hB0 -> one framing_error only, byte_data remains previous value; then byte_valid with 8'hB0.
- rst_n pulsed low during bit 4 of 8'hFF, then 8'h7F sent -> no strobe for the aborted frame; all outputs at reset values; byte_valid with 8'h7F.
- Sequence 8'hA5, 8'h00, 8'hFF at +2% and then -2% baud -> all three bytes decoded correctly in both cases.
